// File: rtl/lrpt_pkg.sv
// Shared LRPT frame-alignment definitions.
// Holds the frame geometry, the sync word, the alignment state enum and
// the rotation type. It also holds the default sync-check thresholds and
// a popcount helper used when sync checking is built in.
package lrpt_pkg;

    localparam int BITS_PER_FRAME   = 80;
    localparam int SYNC_BITS        = 8;
    localparam int POS_W            = $clog2(BITS_PER_FRAME);
    localparam logic [SYNC_BITS-1:0] SYNC_WORD = 8'h27;

    localparam int SYNC_ERR_THRESH  = 2;
    localparam int LOCK_LOSS_FRAMES = 4;

    typedef logic [1:0] rotation_t;

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        SYNC,
        DATA
    } align_state_t;

    function automatic int popcount(input logic [SYNC_BITS-1:0] v);
        int n;
        n = 0;
        for (int k = 0; k < SYNC_BITS; k++) begin
            n += int'(v[k]);
        end
        return n;
    endfunction

endpackage

// File: rtl/iq_derotate.sv
// Combinational removal of the QPSK phase ambiguity.
// The soft-decision path can reuse it.
// Ports:
//   a, b      : raw dibit bits. a is the even stream bit, b the odd one.
//   rotation  : phase ambiguity index, 0..3.
//   i_bit     : de-rotated I bit.
//   q_bit     : de-rotated Q bit.
module iq_derotate
    import lrpt_pkg::*;
(
    input  logic      a,
    input  logic      b,
    input  rotation_t rotation,
    output logic      i_bit,
    output logic      q_bit
);

    always_comb begin
        i_bit = a;
        q_bit = b;
        case (rotation)
            2'd0: begin i_bit = a;  q_bit = b;  end
            2'd1: begin i_bit = b;  q_bit = ~a; end
            2'd2: begin i_bit = ~a; q_bit = ~b; end
            2'd3: begin i_bit = ~b; q_bit = a;  end
            default: ;
        endcase
    end

endmodule

// File: rtl/uw_frame_align.sv
// Frame aligner for the hard-bit stream that follows uw_deinterleave.
//
// After one configuration strobe, the block does the following:
//   - it skips bit_offset bits;
//   - it then tracks 80-bit frames;
//   - it strips the 8-bit sync word from each frame;
//   - it de-rotates the 72 remaining bits;
//   - it emits them as 36 dibits through a single-entry output register
//     with valid/ready handshake.
//
// Optional build macro UW_FRAME_ALIGN_SYNC_CHECK_EN compares each de-rotated
// sync word to SYNC_WORD. It flags bad frames on sync_err, and it drops
// lock after LOCK_LOSS_FRAMES consecutive bad frames. Without the macro,
// sync_err and relock_req are tied 0, and locked holds until reset.
//
// Ports:
//   clk, rst_in          : clock and synchronous active-high reset.
//   cfg_valid            : strobe that latches bit_offset and rotation (IDLE only).
//   bit_offset, rotation : alignment results from uw_deinterleave.
//   valid_in, hard_inp   : input hard-bit stream.
//   ready_rx             : input ready.
//   valid_out, data_out  : de-rotated dibit, [1]=I, [0]=Q.
//   ready_in             : downstream ready.
//   frame_start          : marks the first data dibit of a frame.
//   locked               : alignment active.
//   sync_err             : pulse for a bad sync word.
//   relock_req           : pulse when lock is dropped.
module uw_frame_align
    import lrpt_pkg::*;
`ifdef UW_FRAME_ALIGN_SYNC_CHECK_EN
#(
    parameter int SYNC_ERR_THRESH  = lrpt_pkg::SYNC_ERR_THRESH,
    parameter int LOCK_LOSS_FRAMES = lrpt_pkg::LOCK_LOSS_FRAMES
)
`endif
(
    input  logic             clk,
    input  logic             rst_in,
    input  logic             cfg_valid,
    input  logic [POS_W-1:0] bit_offset,
    input  rotation_t        rotation,
    input  logic             valid_in,
    input  logic             hard_inp,
    output logic             ready_rx,
    output logic             valid_out,
    output logic [1:0]       data_out,
    input  logic             ready_in,
    output logic             frame_start,
    output logic             locked,
    output logic             sync_err,
    output logic             relock_req
);

    localparam logic [POS_W-1:0] FRAME_LEN  = POS_W'(BITS_PER_FRAME);
    localparam logic [POS_W-1:0] FRAME_LAST = POS_W'(BITS_PER_FRAME - 1);
    localparam logic [POS_W-1:0] SYNC_LAST  = POS_W'(SYNC_BITS - 1);
    localparam logic [POS_W-1:0] FS_POS     = POS_W'(SYNC_BITS + 1);
    localparam logic [POS_W-1:0] ONE        = POS_W'(1);

    align_state_t     state, state_nxt;
    logic [POS_W-1:0] pos;
    logic [POS_W-1:0] skip_cnt;
    logic [POS_W-1:0] offset_mod;
    rotation_t        rot;
    logic             a_bit;
    logic             accept;
    logic             out_take;
    logic             i_bit, q_bit;
    logic             sync_lost;

    // bit_offset is at most 127, so one conditional subtract reduces it mod 80.
    assign offset_mod = (bit_offset >= FRAME_LEN) ? (bit_offset - FRAME_LEN) : bit_offset;
    assign accept     = valid_in && ready_rx;
    assign out_take   = valid_out && ready_in;

    // The b bit is the live input. The a bit was latched one accept earlier.
    iq_derotate u_derot (
        .a        (a_bit),
        .b        (hard_inp),
        .rotation (rot),
        .i_bit    (i_bit),
        .q_bit    (q_bit)
    );

`ifdef UW_FRAME_ALIGN_SYNC_CHECK_EN
    localparam int BAD_W = $clog2(LOCK_LOSS_FRAMES + 1);

    logic [SYNC_BITS-3:0] sync_sr;
    logic [SYNC_BITS-1:0] sync_word;
    logic [BAD_W-1:0]     bad_cnt;
    logic                 sync_bad;

    // Only meaningful while the last sync bit is on the input.
    assign sync_word = {sync_sr, i_bit, q_bit};
    assign sync_bad  = popcount(sync_word ^ SYNC_WORD) > SYNC_ERR_THRESH;
    assign sync_lost = sync_bad && (int'(bad_cnt) == LOCK_LOSS_FRAMES - 1);
`else
    assign sync_lost  = 1'b0;
    assign sync_err   = 1'b0;
    assign relock_req = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        ready_rx  = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_valid) state_nxt = (offset_mod != '0) ? SKIP : SYNC;
            end
            SKIP: begin
                ready_rx = 1'b1;
                if (valid_in && skip_cnt == ONE) state_nxt = SYNC;
            end
            SYNC: begin
                ready_rx = 1'b1;
                if (valid_in && pos == SYNC_LAST) state_nxt = sync_lost ? IDLE : DATA;
            end
            DATA: begin
                // Stall the input whenever the output register cannot drain.
                ready_rx = !valid_out || ready_in;
                if (valid_in && ready_rx && pos == FRAME_LAST) state_nxt = SYNC;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state       <= IDLE;
            pos         <= '0;
            skip_cnt    <= '0;
            rot         <= '0;
            a_bit       <= 1'b0;
            valid_out   <= 1'b0;
            data_out    <= '0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
`ifdef UW_FRAME_ALIGN_SYNC_CHECK_EN
            sync_sr     <= '0;
            bad_cnt     <= '0;
            sync_err    <= 1'b0;
            relock_req  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
`ifdef UW_FRAME_ALIGN_SYNC_CHECK_EN
            sync_err   <= 1'b0;
            relock_req <= 1'b0;
`endif
            if (out_take) valid_out <= 1'b0;

            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        rot      <= rotation;
                        skip_cnt <= offset_mod;
                        pos      <= '0;
                        locked   <= 1'b1;
                    end
                end
                SKIP: begin
                    if (accept) skip_cnt <= skip_cnt - ONE;
                end
                SYNC: begin
                    if (accept) begin
                        pos <= pos + ONE;
                        if (!pos[0]) a_bit <= hard_inp;
`ifdef UW_FRAME_ALIGN_SYNC_CHECK_EN
                        if (pos[0]) sync_sr <= {sync_sr[SYNC_BITS-5:0], i_bit, q_bit};
                        if (pos == SYNC_LAST) begin
                            if (sync_bad) begin
                                sync_err <= 1'b1;
                                if (sync_lost) begin
                                    bad_cnt    <= '0;
                                    locked     <= 1'b0;
                                    relock_req <= 1'b1;
                                end else begin
                                    bad_cnt <= bad_cnt + 1'b1;
                                end
                            end else begin
                                bad_cnt <= '0;
                            end
                        end
`endif
                    end
                end
                DATA: begin
                    if (accept) begin
                        pos <= (pos == FRAME_LAST) ? '0 : pos + ONE;
                        if (!pos[0]) begin
                            a_bit <= hard_inp;
                        end else begin
                            // A reload in the same cycle as out_take overrides the clear above.
                            valid_out   <= 1'b1;
                            data_out    <= {i_bit, q_bit};
                            frame_start <= (pos == FS_POS);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uw_frame_align.sv
// Scoreboard bench for uw_frame_align.
// The driver streams directed frames and pushes the expected dibit for
// each frame into a queue. A monitor process pops from the queue on every
// output transfer. The sync-check scenarios are built only when
// UW_FRAME_ALIGN_SYNC_CHECK_EN is defined.
module tb_uw_frame_align;
    import lrpt_pkg::*;

    logic             clk = 1'b0;
    logic             rst_in = 1'b1;
    logic             cfg_valid = 1'b0;
    logic [POS_W-1:0] bit_offset = '0;
    logic [1:0]       rotation = '0;
    logic             valid_in = 1'b0;
    logic             hard_inp = 1'b0;
    logic             ready_rx;
    logic             valid_out;
    logic [1:0]       data_out;
    logic             ready_in = 1'b1;
    logic             frame_start;
    logic             locked;
    logic             sync_err;
    logic             relock_req;

    always #5 clk = ~clk;

    uw_frame_align dut (
        .clk         (clk),
        .rst_in      (rst_in),
        .cfg_valid   (cfg_valid),
        .bit_offset  (bit_offset),
        .rotation    (rotation),
        .valid_in    (valid_in),
        .hard_inp    (hard_inp),
        .ready_rx    (ready_rx),
        .valid_out   (valid_out),
        .data_out    (data_out),
        .ready_in    (ready_in),
        .frame_start (frame_start),
        .locked      (locked),
        .sync_err    (sync_err),
        .relock_req  (relock_req)
    );

    int         n_cmp = 0;
    int         n_fail = 0;
    int         n_sync_err = 0;
    int         n_relock = 0;
    logic [2:0] sb[$];
    bit         rnd_mode = 1'b0;
    bit         hold = 1'b0;

    localparam logic [71:0] P0 = 72'h0123456789ABCDEF5A;
    localparam logic [71:0] P1 = 72'hFEDCBA9876543210C3;
    localparam logic [71:0] P2 = 72'hF0F00FF0AA55CC3396;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] derot(input logic a, input logic b, input logic [1:0] r);
        case (r)
            2'd0:    return {a, b};
            2'd1:    return {b, ~a};
            2'd2:    return {~a, ~b};
            default: return {~b, a};
        endcase
    endfunction

    // Raw (a,b) that de-rotates to (i,q).
    function automatic logic [1:0] rerot(input logic i, input logic q, input logic [1:0] r);
        case (r)
            2'd0:    return {i, q};
            2'd1:    return {~q, i};
            2'd2:    return {~i, ~q};
            default: return {q, ~i};
        endcase
    endfunction

    // Downstream ready, updated 2 time units after each rising edge.
    always @(posedge clk) begin
        #2;
        ready_in = hold ? 1'b0 : (rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1);
    end

    // Monitor: pops one expectation per output transfer, and holds data steady under stall.
    logic [1:0] held_d;
    logic       held_fs;
    bit         stalled = 1'b0;
    always @(negedge clk) begin
        if (rst_in) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", 32'(valid_out), 32'd1);
                check("stall_data", 32'(data_out), 32'(held_d));
                check("stall_fs", 32'(frame_start), 32'(held_fs));
            end
            stalled = valid_out && !ready_in;
            held_d  = data_out;
            held_fs = frame_start;
            if (valid_out && ready_in) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_dibit: got %0h expected none", data_out);
                end else begin
                    logic [2:0] e;
                    e = sb.pop_front();
                    check("dibit", 32'(data_out), 32'(e[2:1]));
                    check("frame_start", 32'(frame_start), 32'(e[0]));
                end
            end
            if (sync_err) n_sync_err++;
            if (relock_req) n_relock++;
        end
    end

    task automatic send_bit(input logic b, input bit is_data);
        bit acc;
        int t;
        t = 0;
        valid_in = 1'b1;
        hard_inp = b;
        forever begin
            @(negedge clk);
            acc = ready_rx;
            if (is_data) check("ready_rx_bp", 32'(ready_rx), 32'(!(valid_out && !ready_in)));
            @(posedge clk);
            #1;
            if (acc) break;
            t++;
            if (t > 300) begin
                n_cmp++;
                n_fail++;
                $display("FAIL send_timeout: ready_rx got 0 expected 1");
                break;
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] sw, input logic [71:0] p, input logic [1:0] r,
                              input int nbits, input bit lat_chk);
        logic [1:0] raw;
        for (int k = 0; k < 4; k++) begin
            raw = rerot(sw[7-2*k], sw[6-2*k], r);
            if (2*k < nbits) send_bit(raw[1], 1'b0);
            if (2*k + 1 < nbits) send_bit(raw[0], 1'b0);
        end
        for (int k = 0; k < 36; k++) begin
            if (8 + 2*k >= nbits) return;
            send_bit(p[71-2*k], 1'b1);
            if (lat_chk && k == 0) check("lat_before", 32'(valid_out), 32'd0);
            if (8 + 2*k + 1 >= nbits) return;
            sb.push_back({derot(p[71-2*k], p[70-2*k], r), k == 0});
            send_bit(p[70-2*k], 1'b1);
            if (lat_chk && k == 0) begin
                check("lat_valid", 32'(valid_out), 32'd1);
                check("lat_fs", 32'(frame_start), 32'd1);
            end
        end
    endtask

    task automatic send_junk(input int n);
        for (int k = 0; k < n; k++) send_bit(1'(k % 3 == 0), 1'b0);
    endtask

    task automatic do_reset();
        valid_in = 1'b0;
        rst_in   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_in = 1'b0;
        sb.delete();
    endtask

    task automatic do_cfg(input int off, input logic [1:0] r);
        cfg_valid  = 1'b1;
        bit_offset = POS_W'(off);
        rotation   = r;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        valid_in = 1'b0;
        while (sb.size() != 0 && t < 400) begin
            @(posedge clk);
            t++;
        end
        #1;
        check(name, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_valid_out", 32'(valid_out), 32'd0);
        check("rst_ready_rx", 32'(ready_rx), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        check("rst_sync_err", 32'(sync_err), 32'd0);
        check("rst_relock", 32'(relock_req), 32'd0);
        @(posedge clk);
        #1;

        // Offset 0, rotation 0, three frames
        do_cfg(0, 2'd0);
        check("cfg_locked", 32'(locked), 32'd1);
        send_frame(8'h27, P0, 2'd0, 80, 1'b1);
        send_frame(8'h27, P1, 2'd0, 80, 1'b0);
        send_frame(8'h27, P2, 2'd0, 80, 1'b0);
        drain("drain_rot0");
        check("no_sync_err", 32'(n_sync_err), 32'd0);

        // Offset 37, rotation 1; ready_rx low in IDLE
        do_reset();
        valid_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("idle_ready_rx", 32'(ready_rx), 32'd0);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        do_cfg(37, 2'd1);
        send_junk(37);
        send_frame(8'h27, P1, 2'd1, 80, 1'b0);
        send_frame(8'h27, P0, 2'd1, 80, 1'b0);
        drain("drain_off37");

        // Odd offset 1, rotation 2
        do_reset();
        do_cfg(1, 2'd2);
        send_junk(1);
        send_frame(8'h27, P2, 2'd2, 80, 1'b0);
        send_frame(8'h27, P1, 2'd2, 80, 1'b0);
        drain("drain_off1");

        // Offset 81 behaves as offset 1
        do_reset();
        do_cfg(81, 2'd0);
        send_junk(1);
        send_frame(8'h27, P0, 2'd0, 80, 1'b0);
        drain("drain_off81");

        // Random backpressure, rotation 3
        do_reset();
        rnd_mode = 1'b1;
        do_cfg(0, 2'd3);
        send_frame(8'h27, P0, 2'd3, 80, 1'b0);
        send_frame(8'h27, P2, 2'd3, 80, 1'b0);
        send_frame(8'h27, P1, 2'd3, 80, 1'b0);
        drain("drain_bp");
        rnd_mode = 1'b0;

        // Reset mid-DATA after bit 50, with an output pending
        do_reset();
        do_cfg(0, 2'd0);
        send_frame(8'h27, P1, 2'd0, 50, 1'b0);
        valid_in = 1'b0;
        hold     = 1'b1;
        rst_in   = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_valid_out", 32'(valid_out), 32'd0);
        check("midrst_locked", 32'(locked), 32'd0);
        cfg_valid = 1'b1;
        @(posedge clk);
        #1;
        rst_in    = 1'b0;
        cfg_valid = 1'b0;
        sb.delete();
        check("rst_wins_locked", 32'(locked), 32'd0);
        check("rst_wins_ready", 32'(ready_rx), 32'd0);
        hold = 1'b0;
        @(posedge clk);
        #1;
        do_cfg(0, 2'd0);
        send_frame(8'h27, P2, 2'd0, 80, 1'b1);
        drain("drain_recfg");

`ifdef UW_FRAME_ALIGN_SYNC_CHECK_EN
        // Three sync errors per frame: lock lost on the fourth frame
        do_reset();
        n_sync_err = 0;
        n_relock   = 0;
        do_cfg(0, 2'd0);
        for (int f = 0; f < 3; f++) send_frame(8'h20, P0, 2'd0, 80, 1'b0);
        send_frame(8'h20, P1, 2'd0, 8, 1'b0);
        valid_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("sc_sync_err_cnt", 32'(n_sync_err), 32'd4);
        check("sc_relock_cnt", 32'(n_relock), 32'd1);
        check("sc_locked", 32'(locked), 32'd0);
        check("sc_idle_ready", 32'(ready_rx), 32'd0);
        drain("drain_sc_bad");

        // Two sync errors per frame are tolerated
        do_reset();
        n_sync_err = 0;
        n_relock   = 0;
        do_cfg(0, 2'd1);
        send_frame(8'h24, P0, 2'd1, 80, 1'b0);
        send_frame(8'h24, P2, 2'd1, 80, 1'b0);
        drain("drain_sc_ok");
        check("sc2_sync_err_cnt", 32'(n_sync_err), 32'd0);
        check("sc2_locked", 32'(locked), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
